// File: rtl/bellman_ford.sv
// rtl/bellman_ford.sv - single-source shortest paths by sequential Bellman-Ford relaxation
// One (i,j) edge is examined every three cycles; passes stop early once a pass makes no update.
module bellman_ford #(
   parameter int NODES        = 4,
   parameter int WEIGHT_WIDTH = 15,
   parameter int PRED_WIDTH   = 1,
   parameter int VERT_WIDTH   = WEIGHT_WIDTH + PRED_WIDTH + 2
) (
   input  logic                           clk,
   input  logic                           bf_reset,
   input  logic                           bf_start,
   input  logic [PRED_WIDTH:0]            src,
   input  logic signed [WEIGHT_WIDTH:0]   adjmat [NODES][NODES],
   output logic [VERT_WIDTH:0]            vertmat [NODES],
   output logic                           bf_busy,
   output logic                           bf_done,
   output logic [PRED_WIDTH:0]            passes
);

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      READ_SOURCE,
      READ_DESTINATION,
      RELAX,
      DONE
   } state_t;

   localparam logic signed [WEIGHT_WIDTH:0] INF     = {1'b0, {WEIGHT_WIDTH{1'b1}}};
   localparam logic signed [WEIGHT_WIDTH:0] NEG_MIN = {1'b1, {WEIGHT_WIDTH{1'b0}}};
   // Last vertex index, which is also the pass cap (NODES-1).
   localparam logic [PRED_WIDTH:0]          LAST    = (PRED_WIDTH + 1)'(NODES - 1);

   state_t                        state_q, state_d;
   logic [PRED_WIDTH:0]           src_q, src_d;
   logic [PRED_WIDTH:0]           i_q, i_d;
   logic [PRED_WIDTH:0]           j_q, j_d;
   logic signed [WEIGHT_WIDTH:0]  svw_q, svw_d;
   logic signed [WEIGHT_WIDTH:0]  e_q, e_d;
   logic signed [WEIGHT_WIDTH:0]  dvw_q, dvw_d;
   logic                          flag_q, flag_d;
   logic [PRED_WIDTH:0]           passes_q, passes_d;
   logic                          busy_q, busy_d;
   logic                          done_q, done_d;
   logic signed [WEIGHT_WIDTH:0]  dist_q [NODES];
   logic signed [WEIGHT_WIDTH:0]  dist_d [NODES];
   logic [PRED_WIDTH:0]           pred_q [NODES];
   logic [PRED_WIDTH:0]           pred_d [NODES];

   logic [WEIGHT_WIDTH+1:0]       sum_wide;
   logic signed [WEIGHT_WIDTH:0]  sum_sat;
   logic                          relax;
   logic                          flag_nx;
   logic [PRED_WIDTH:0]           pass_inc;

   // Overflow shows as disagreement between the two top bits of the widened sum.
   always_comb begin
      sum_wide = {svw_q[WEIGHT_WIDTH], svw_q} + {e_q[WEIGHT_WIDTH], e_q};
      if (sum_wide[WEIGHT_WIDTH+1] != sum_wide[WEIGHT_WIDTH]) begin
         sum_sat = sum_wide[WEIGHT_WIDTH+1] ? NEG_MIN : INF;
      end else begin
         sum_sat = sum_wide[WEIGHT_WIDTH:0];
      end
      relax    = (e_q != '0) && (i_q != j_q) && (svw_q != INF) && (sum_sat < dvw_q);
      flag_nx  = flag_q | relax;
      pass_inc = passes_q + 1'b1;
   end

   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      i_d      = i_q;
      j_d      = j_q;
      svw_d    = svw_q;
      e_d      = e_q;
      dvw_d    = dvw_q;
      flag_d   = flag_q;
      passes_d = passes_q;
      busy_d   = busy_q;
      done_d   = done_q;
      dist_d   = dist_q;
      pred_d   = pred_q;

      case (state_q)
         IDLE, DONE: begin
            if (bf_start) begin
               src_d    = src;
               passes_d = '0;
               flag_d   = 1'b0;
               done_d   = 1'b0;
               busy_d   = 1'b1;
               state_d  = INIT;
            end else if (state_q == DONE) begin
               done_d = 1'b1;
               busy_d = 1'b0;
            end
         end
         INIT: begin
            for (int k = 0; k < NODES; k++) begin
               dist_d[k] = INF;
               pred_d[k] = (PRED_WIDTH + 1)'(k);
            end
            dist_d[src_q] = '0;
            pred_d[src_q] = src_q;
            i_d     = '0;
            j_d     = '0;
            state_d = READ_SOURCE;
         end
         READ_SOURCE: begin
            svw_d   = dist_q[i_q];
            e_d     = adjmat[i_q][j_q];
            state_d = READ_DESTINATION;
         end
         READ_DESTINATION: begin
            dvw_d   = dist_q[j_q];
            state_d = RELAX;
         end
         RELAX: begin
            if (relax) begin
               dist_d[j_q] = sum_sat;
               pred_d[j_q] = i_q;
               flag_d      = 1'b1;
            end
            state_d = READ_SOURCE;
            if (j_q == LAST) begin
               j_d = '0;
               if (i_q == LAST) begin
                  i_d      = '0;
                  passes_d = pass_inc;
                  if (!flag_nx || pass_inc == LAST) begin
                     state_d = DONE;
                  end else begin
                     flag_d = 1'b0;
                  end
               end else begin
                  i_d = i_q + 1'b1;
               end
            end else begin
               j_d = j_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge bf_reset) begin
      if (bf_reset) begin
         state_q  <= IDLE;
         src_q    <= '0;
         i_q      <= '0;
         j_q      <= '0;
         svw_q    <= '0;
         e_q      <= '0;
         dvw_q    <= '0;
         flag_q   <= 1'b0;
         passes_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         for (int k = 0; k < NODES; k++) begin
            dist_q[k] <= '0;
            pred_q[k] <= '0;
         end
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         i_q      <= i_d;
         j_q      <= j_d;
         svw_q    <= svw_d;
         e_q      <= e_d;
         dvw_q    <= dvw_d;
         flag_q   <= flag_d;
         passes_q <= passes_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         for (int k = 0; k < NODES; k++) begin
            dist_q[k] <= dist_d[k];
            pred_q[k] <= pred_d[k];
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NODES; k++) begin
         vertmat[k] = (VERT_WIDTH + 1)'({pred_q[k], dist_q[k]});
      end
   end

   assign bf_busy = busy_q;
   assign bf_done = done_q;
   assign passes  = passes_q;

endmodule

// File: tb/tb_bellman_ford.sv
// tb/tb_bellman_ford.sv - directed and random runs of bellman_ford against a plain shortest-path model
module tb_bellman_ford;
   localparam int N   = 4;
   localparam int INF = 32767;

   logic              clk = 1'b0;
   logic              bf_reset;
   logic              bf_start;
   logic [1:0]        src;
   logic signed [15:0] adjmat [N][N];
   logic [18:0]       vertmat [N];
   logic              bf_busy;
   logic              bf_done;
   logic [1:0]        passes;

   int vectors = 0;
   int fails   = 0;
   int cyc     = 0;
   int w [N][N];
   int exp_d [N];
   int exp_p [N];
   int exp_pass;

   always #5 clk = ~clk;

   bellman_ford #(.NODES(4), .WEIGHT_WIDTH(15), .PRED_WIDTH(1)) dut (
      .clk      (clk),
      .bf_reset (bf_reset),
      .bf_start (bf_start),
      .src      (src),
      .adjmat   (adjmat),
      .vertmat  (vertmat),
      .bf_busy  (bf_busy),
      .bf_done  (bf_done),
      .passes   (passes)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic clear_graph();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            w[i][j] = 0;
   endtask

   task automatic apply_graph();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            adjmat[i][j] = 16'(w[i][j]);
   endtask

   // Edge-by-edge relaxation in j-fastest order with early exit and a NODES-1 pass cap.
   task automatic model(input int s);
      int upd;
      int sum;
      for (int k = 0; k < N; k++) begin
         exp_d[k] = INF;
         exp_p[k] = k;
      end
      exp_d[s] = 0;
      exp_p[s] = s;
      exp_pass = 0;
      do begin
         upd = 0;
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               if (w[i][j] != 0 && i != j && exp_d[i] != INF) begin
                  sum = exp_d[i] + w[i][j];
                  if (sum > 32767)  sum = 32767;
                  if (sum < -32768) sum = -32768;
                  if (sum < exp_d[j]) begin
                     exp_d[j] = sum;
                     exp_p[j] = i;
                     upd = 1;
                  end
               end
            end
         end
         exp_pass++;
      end while (upd != 0 && exp_pass < N - 1);
   endtask

   task automatic start_run(input int s, input string tag);
      apply_graph();
      @(negedge clk);
      src      = 2'(s);
      bf_start = 1'b1;
      @(posedge clk);
      cyc = 0;
      #1;
      chk({tag, "_busy_on_accept"}, bf_busy, 1);
      chk({tag, "_done_dropped"}, bf_done, 0);
      @(negedge clk);
      bf_start = 1'b0;
      src      = 2'($urandom);
   endtask

   task automatic wait_done(input string tag);
      while (bf_done !== 1'b1 && cyc < 1000) tick();
      chk({tag, "_latency"}, cyc, 2 + 3 * N * N * exp_pass);
   endtask

   task automatic check_results(input string tag);
      repeat (3) tick();
      chk({tag, "_done_held"}, bf_done, 1);
      chk({tag, "_busy_low"}, bf_busy, 0);
      chk({tag, "_passes"}, passes, exp_pass);
      for (int k = 0; k < N; k++) begin
         chk($sformatf("%s_dist%0d", tag, k), $signed(vertmat[k][15:0]), exp_d[k]);
         chk($sformatf("%s_pred%0d", tag, k), vertmat[k][17:16], exp_p[k]);
         chk($sformatf("%s_msb%0d", tag, k), vertmat[k][18], 0);
      end
   endtask

   task automatic run_case(input int s, input string tag);
      model(s);
      start_run(s, tag);
      wait_done(tag);
      check_results(tag);
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_busy"}, bf_busy, 0);
      chk({tag, "_done"}, bf_done, 0);
      chk({tag, "_passes"}, passes, 0);
      for (int k = 0; k < N; k++)
         chk($sformatf("%s_vert%0d", tag, k), vertmat[k], 0);
   endtask

   task automatic graph_basic();
      clear_graph();
      w[0][1] = 5;
      w[1][2] = -3;
      w[0][2] = 4;
   endtask

   initial begin
      int d1, d2, relaxable;
      clear_graph();
      apply_graph();
      bf_reset = 1'b1;
      bf_start = 1'b1;
      src      = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      check_cleared("reset_held");
      @(negedge clk);
      bf_reset = 1'b0;
      bf_start = 1'b0;

      graph_basic();
      run_case(0, "basic");
      chk("basic_dist1_const", $signed(vertmat[1][15:0]), 5);
      chk("basic_dist2_const", $signed(vertmat[2][15:0]), 2);
      chk("basic_pred2_const", vertmat[2][17:16], 1);
      chk("basic_passes_const", passes, 2);

      clear_graph();
      w[0][1] = 1;
      w[1][2] = -2;
      w[2][1] = -2;
      run_case(0, "negcyc");
      chk("negcyc_passes_cap", passes, 3);
      d1 = $signed(vertmat[1][15:0]);
      d2 = $signed(vertmat[2][15:0]);
      relaxable = ((d1 - 2 < d2) || (d2 - 2 < d1)) ? 1 : 0;
      chk("negcyc_relaxable", relaxable, 1);

      clear_graph();
      w[0][1] = -30000;
      w[1][2] = -30000;
      run_case(0, "sat");
      chk("sat_dist2_const", $signed(vertmat[2][15:0]), -32768);
      chk("sat_pred2_const", vertmat[2][17:16], 1);

      graph_basic();
      model(0);
      start_run(0, "midreset");
      repeat (20) tick();
      #2;
      bf_reset = 1'b1;
      #1;
      check_cleared("midreset");
      @(negedge clk);
      bf_reset = 1'b0;
      run_case(0, "after_reset");

      graph_basic();
      model(0);
      start_run(0, "restart_busy");
      repeat (10) tick();
      @(negedge clk);
      bf_start = 1'b1;
      src      = 2'd3;
      tick();
      @(negedge clk);
      bf_start = 1'b0;
      wait_done("restart_busy");
      check_results("restart_busy");

      run_case(3, "from_done");
      chk("from_done_dist3_const", $signed(vertmat[3][15:0]), 0);

      for (int r = 0; r < 8; r++) begin
         clear_graph();
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               if ($urandom_range(0, 9) < 5) begin
                  if (r >= 6) w[i][j] = int'($urandom_range(0, 65535)) - 32768;
                  else        w[i][j] = int'($urandom_range(0, 60)) - 15;
               end
            end
         end
         run_case(int'($urandom_range(0, N - 1)), $sformatf("rand%0d", r));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
